keypad_encoder: RTL and testbench

Scans a 4x4 active-low matrix keypad, debounces key presses and delivers one 4-bit key code per press to the calculator core over a valid/ready handshake. It is the producer end of the calculator's `cmd` input: it turns raw row/column contacts into clean, single-shot command codes that the core consumes.

---
 rtl/keypad_encoder.sv | 202 ++++++++++++++++++++
 tb/tb_keypad_encoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// keypad_encoder: 4x4 active-low matrix scanner with debounce.
// Emits one key code per press over a valid/ready handshake.
module keypad_encoder #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBNC,
    S_EMIT,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    meta_q;
  logic [3:0]    rs_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    pat_q, pat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic          sample;
  logic [CW-1:0] cnt_inc;

  // Lowest active row wins when several rows are low.
  function automatic logic [3:0] key_code(
    input logic [3:0] pat,
    input logic [1:0] c
  );
    logic [1:0] r;
    logic [3:0] k;
    priority case (1'b1)
      !pat[0]: r = 2'd0;
      !pat[1]: r = 2'd1;
      !pat[2]: r = 2'd2;
      default: r = 2'd3;
    endcase
    unique case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hF;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= 4'hF;
      rs_q   <= 4'hF;
    end else begin
      meta_q <= row;
      rs_q   <= meta_q;
    end
  end

  assign sample  = (div_q == DIV_LAST);
  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    div_d = div_q + 1'b1;
    if (sample) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_SCAN;
      div_q   <= '0;
      col_q   <= 2'd0;
      pat_q   <= 4'hF;
      cnt_q   <= '0;
      cmd_q   <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      col_q   <= col_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    valid_d = valid_q;
    held_d  = held_q;
    unique case (state_q)
      S_SCAN: begin
        if (sample) begin
          if (rs_q != 4'hF) begin
            pat_d = rs_q;
            cnt_d = CNT_ONE;
            if (CNT_DONE == CNT_ONE) begin
              cmd_d   = key_code(rs_q, col_q);
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = S_EMIT;
            end else begin
              state_d = S_DEBNC;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      S_DEBNC: begin
        if (sample) begin
          if (rs_q == pat_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              cmd_d   = key_code(pat_q, col_q);
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = S_EMIT;
            end
          end else begin
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = S_SCAN;
          end
        end
      end
      S_EMIT: begin
        // Row activity is ignored here; release is judged afterwards.
        if (cmd_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sample) begin
          if (rs_q == 4'hF) begin
            if (cnt_inc == CNT_DONE) begin
              cnt_d   = '0;
              held_d  = 1'b0;
              col_d   = col_q + 2'd1;
              state_d = S_SCAN;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = S_SCAN;
      end
    endcase
  end

  always_comb begin
    col = 4'hF;
    col[col_q] = 1'b0;
  end

  assign cmd       = cmd_q;
  assign cmd_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: randomized key presses on a physical keypad
// model, scoreboarded against the key map and handshake rules.
module tb_keypad_encoder;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready = 1'b1;
  logic       key_held;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic       pressed [4][4];
  logic [3:0] keymap  [4][4];
  logic [3:0] expq [$];

  keypad_encoder #(
    .SCAN_DIV(4),
    .DEBOUNCE(3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .col      (col),
    .row      (row),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .key_held (key_held)
  );

  always #5 clock = ~clock;

  // Physical keypad: a pressed key shorts its row to its column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    chk("col_onehot", 32'($countones(~col)), 1);
    if (reset && cmd_valid && cmd_ready) begin
      xfers++;
      if (expq.size() == 0) chk("extra_xfer", {28'h0, cmd}, 32'hFFFF);
      else chk("xfer_code", {28'h0, cmd}, {28'h0, expq.pop_front()});
    end
  end

  task automatic release_all();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (cmd_valid) begin
        ok = 1;
        break;
      end
    end
    chk("valid_seen", 32'(ok), 1);
  endtask

  task automatic wait_xfer(input int x0);
    for (int i = 0; i < 20 && xfers == x0; i++) @(negedge clock);
    #1;
    chk("xfer_seen", 32'(xfers - x0), 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!key_held) begin
        ok = 1;
        break;
      end
    end
    chk("held_fall", 32'(ok), 1);
  endtask

  task automatic do_press(input int r, input int r2, input int c,
                          input int stall, input int hold);
    int x0;
    int rmin;
    logic [3:0] e;
    release_all();
    rmin = r;
    if (r2 >= 0 && r2 < r) rmin = r2;
    e = keymap[rmin][c];
    expq.push_back(e);
    x0 = xfers;
    cmd_ready = (stall == 0);
    pressed[r][c] = 1'b1;
    if (r2 >= 0) pressed[r2][c] = 1'b1;
    wait_valid();
    chk("held_at_valid", 32'(key_held), 1);
    if (stall > 0) begin
      repeat (stall) @(posedge clock);
      #1;
      chk("stall_valid", 32'(cmd_valid), 1);
      chk("stall_cmd", {28'h0, cmd}, {28'h0, e});
      cmd_ready = 1'b1;
    end
    wait_xfer(x0);
    repeat (hold) @(posedge clock);
    #1;
    release_all();
    // Release needs 2 sync cycles plus 3 sample intervals.
    repeat (10) @(posedge clock);
    #1;
    chk("held_early", 32'(key_held), 1);
    repeat (4) @(posedge clock);
    #1;
    chk("held_late", 32'(key_held), 0);
    chk("one_xfer", 32'(xfers - x0), 1);
  endtask

  initial begin
    int x0;
    logic [3:0] e;
    logic [3:0] seen;
    keymap = '{'{4'h1, 4'h2, 4'h3, 4'hA},
               '{4'h4, 4'h5, 4'h6, 4'hB},
               '{4'h7, 4'h8, 4'h9, 4'hC},
               '{4'hE, 4'h0, 4'hF, 4'hD}};
    release_all();
    #12;
    chk("rst_col", {28'h0, col}, 32'hE);
    chk("rst_cmd", {28'h0, cmd}, 0);
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_held", 32'(key_held), 0);

    @(negedge clock);
    reset = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clock);
      #1;
      e = 4'hF;
      e[(n / 4) % 4] = 1'b0;
      chk("idle_col", {28'h0, col}, {28'h0, e});
      chk("idle_valid", 32'(cmd_valid | key_held), 0);
    end

    do_press(1, -1, 1, 0, 8);
    do_press(3, -1, 0, 0, 3);
    do_press(3, -1, 3, 0, 5);

    // Backpressure with release during the stall.
    release_all();
    cmd_ready = 1'b0;
    pressed[0][3] = 1'b1;
    wait_valid();
    x0 = xfers;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (i == 10) release_all();
      chk("bp_valid", 32'(cmd_valid), 1);
      chk("bp_cmd", {28'h0, cmd}, 32'hA);
    end
    expq.push_back(4'hA);
    cmd_ready = 1'b1;
    wait_xfer(x0);
    wait_idle();
    seen = 4'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      seen = seen | ~col;
    end
    chk("bp_resume", {28'h0, seen}, 32'hF);
    chk("bp_one", 32'(xfers - x0), 1);

    // Bounce on "9": two good samples, one open, then stable.
    release_all();
    cmd_ready = 1'b1;
    x0 = xfers;
    pressed[2][2] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (col == 4'b1011) break;
    end
    chk("bnc_col", {28'h0, col}, 32'hB);
    repeat (9) @(posedge clock);
    #1;
    release_all();
    repeat (4) @(posedge clock);
    #1;
    pressed[2][2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bnc_quiet", 32'(cmd_valid), 0);
    end
    expq.push_back(4'h9);
    wait_valid();
    wait_xfer(x0);
    release_all();
    wait_idle();
    chk("bnc_one", 32'(xfers - x0), 1);

    // Two rows in column 0 held for 100 samples.
    do_press(2, 1, 0, 0, 400);

    for (int k = 0; k < 10; k++) begin
      int r, r2, c;
      r  = $urandom_range(0, 3);
      c  = $urandom_range(0, 3);
      r2 = -1;
      if ($urandom_range(0, 1) == 1) r2 = (r + $urandom_range(1, 3)) % 4;
      do_press(r, r2, c, $urandom_range(0, 6), $urandom_range(1, 30));
    end

    // Reset while a "7" is pending.
    release_all();
    cmd_ready = 1'b0;
    pressed[2][0] = 1'b1;
    wait_valid();
    chk("pre_rst_cmd", {28'h0, cmd}, 32'h7);
    x0 = xfers;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(cmd_valid), 0);
    chk("mid_rst_cmd", {28'h0, cmd}, 0);
    chk("mid_rst_col", {28'h0, col}, 32'hE);
    chk("mid_rst_held", 32'(key_held), 0);
    release_all();
    @(negedge clock);
    reset = 1'b1;
    cmd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      chk("post_rst_quiet", 32'(cmd_valid | key_held), 0);
    end
    chk("post_rst_xfers", 32'(xfers - x0), 0);
    chk("queue_empty", 32'(expq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
